store_access_unit: RTL and testbench

STORE_ACCESS_UNIT -- requirements
Module: store_access_unit

---
 rtl/store_pkg.sv | 30 +++
 rtl/store_merge.sv | 56 +++++
 rtl/store_access_unit.sv | 138 +++++++++++++
 tb/tb_store_access_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Purpose : shared definitions for the store access unit. Holds the FSM state
//           enum, the store-width function3 codes and small decode helpers.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package store_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   // Only byte, half and word stores exist; every other encoding is rejected.
   function automatic logic f3_is_valid(input logic [2:0] f3);
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
   endfunction

   // Natural alignment: halves on even bytes, words on word boundaries.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      return ((f3 == F3_SH) && off[0]) || ((f3 == F3_SW) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/store_merge.sv
// -----------------------------------------------------------------------------
// store_merge
// Purpose : combinational byte-lane replacement for read-modify-write stores.
// Ports   : i_old_word  - word read back from memory
//           i_wdata     - LSB-justified store data
//           i_function3 - store width (F3_SB / F3_SH / F3_SW)
//           i_offset    - byte offset within the word (addr[1:0])
//           o_merged    - word to write back
// -----------------------------------------------------------------------------
module store_merge
   import store_pkg::*;
(
   input  logic [31:0] i_old_word,
   input  logic [31:0] i_wdata,
   input  logic [2:0]  i_function3,
   input  logic [1:0]  i_offset,
   output logic [31:0] o_merged
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic       w_sel;
         logic [7:0] w_src;

         // Each lane decides independently whether it is overwritten and
         // which byte of the store data lands in it.
         always_comb begin
            w_sel = 1'b0;
            w_src = i_wdata[8*gi +: 8];
            case (i_function3)
               F3_SB: begin
                  w_sel = (i_offset == 2'(gi));
                  w_src = i_wdata[7:0];
               end
               F3_SH: begin
                  // Half-word occupies lanes {addr[1],0} and {addr[1],1};
                  // addr[0] is deliberately ignored here.
                  w_sel = (i_offset[1] == 1'(gi / 2));
                  w_src = i_wdata[8*(gi % 2) +: 8];
               end
               F3_SW: begin
                  w_sel = 1'b1;
                  w_src = i_wdata[8*gi +: 8];
               end
               default: begin
                  w_sel = 1'b0;
               end
            endcase
         end

         assign o_merged[8*gi +: 8] = w_sel ? w_src : i_old_word[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/store_access_unit.sv
// -----------------------------------------------------------------------------
// store_access_unit
// Purpose : executes sb/sh/sw stores against a word-wide memory. Word stores
//           write directly; byte/half stores read the word first and write
//           back the merged result. Illegal requests produce a one-cycle err.
// Config  : define STORE_MISALIGN_TRAP_EN to reject misaligned sh/sw; when it
//           is undefined the low address bits are simply ignored.
// Ports   : clk, rst (sync, active-high)
//           req_valid/req_ready      - request handshake
//           function3, addr, wdata   - store request
//           mem_addr, mem_rd_en, mem_rdata, mem_wr_en, mem_wdata - memory port
//           done, err                - one-cycle completion / reject pulses
// -----------------------------------------------------------------------------
module store_access_unit
   import store_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            function3,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd_en,
   input  logic [31:0]           mem_rdata,
   output logic                  mem_wr_en,
   output logic [31:0]           mem_wdata,
   output logic                  done,
   output logic                  err
);

   state_t                r_state;
   logic [2:0]            r_f3;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic                  r_rd_en;
   logic                  r_wr_en;
   logic                  r_done;
   logic                  r_err;

   logic                  w_accept;
   logic                  w_reject;
   logic [31:0]           w_merged;

   assign w_accept = req_valid && (r_state == ST_IDLE);

`ifdef STORE_MISALIGN_TRAP_EN
   assign w_reject = !f3_is_valid(function3) || is_misaligned(function3, addr[1:0]);
`else
   assign w_reject = !f3_is_valid(function3);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_f3    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rd_en <= 1'b0;
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         // Strobes are single-cycle unless the next state re-asserts them.
         r_rd_en <= 1'b0;
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_f3    <= function3;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  if (w_reject) begin
                     r_state <= ST_ERROR;
                     r_err   <= 1'b1;
                  end else if (function3 == F3_SW) begin
                     r_state <= ST_WRITE;
                     r_wr_en <= 1'b1;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_READ;
                     r_rd_en <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               r_state <= ST_WRITE;
               r_wr_en <= 1'b1;
               r_done  <= 1'b1;
            end
            ST_WRITE: begin
               r_state <= ST_IDLE;
            end
            ST_ERROR: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Old word arrives on mem_rdata during WRITE, so the merge is combinational
   // on the live read data rather than a registered copy.
   store_merge u_merge (
      .i_old_word  (mem_rdata),
      .i_wdata     (r_wdata),
      .i_function3 (r_f3),
      .i_offset    (r_addr[1:0]),
      .o_merged    (w_merged)
   );

   // Reset overrides the registered outputs combinationally so that a store
   // caught in READ/WRITE never strobes memory during the reset cycle.
   assign req_ready = (r_state == ST_IDLE) || rst;
   assign mem_rd_en = r_rd_en && !rst;
   assign mem_wr_en = r_wr_en && !rst;
   assign done      = r_done && !rst;
   assign err       = r_err && !rst;
   assign mem_wdata = (r_wr_en && !rst) ? w_merged : 32'h0;

   // In IDLE the address tracks the incoming request so it is already valid
   // in the acceptance cycle; afterwards the captured copy holds it stable.
   always_comb begin
      mem_addr = '0;
      if (!rst) begin
         if (r_state == ST_IDLE) begin
            mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00};
         end else begin
            mem_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
         end
      end
   end

endmodule

// File: tb/tb_store_access_unit.sv
module tb_store_access_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  function3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_wr_en;
   logic [31:0] mem_wdata;
   logic        done;
   logic        err;

   store_access_unit #(.ADDR_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .function3 (function3),
      .addr      (addr),
      .wdata     (wdata),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected behaviour of one future cycle.
   typedef struct {
      bit          rd;
      bit          wr;
      bit          dn;
      bit          er;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mem [0:255];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_txn = 0;
   int          dut_acc = 0;

   // Last sampled DUT outputs.
   logic        s_ready, s_rd, s_wr, s_done, s_err;
   logic [31:0] s_addr, s_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Reference semantics of an accepted request, from the store rules.
   task automatic model_accept();
      exp_t        e;
      logic [31:0] old, mask, merged, al;
      int          sh;
      bit          bad;
      e  = '{default: '0};
      al = {addr[31:2], 2'b00};
      e.f3 = function3;
      e.addr = al;
      bad = !(function3 inside {3'b000, 3'b001, 3'b010});
`ifdef STORE_MISALIGN_TRAP_EN
      if (function3 == 3'b001 && addr[0]) bad = 1;
      if (function3 == 3'b010 && addr[1:0] != 2'b00) bad = 1;
`endif
      if (bad) begin
         e.er = 1;
         q.push_back(e);
      end else if (function3 == 3'b010) begin
         e.wr = 1; e.dn = 1; e.wdata = wdata;
         q.push_back(e);
      end else begin
         old = mem[al[9:2]];
         if (function3 == 3'b000) begin
            sh = 8 * int'(addr[1:0]);
            mask = 32'h0000_00FF << sh;
         end else begin
            sh = 16 * int'(addr[1]);
            mask = 32'h0000_FFFF << sh;
         end
         merged = (old & ~mask) | ((wdata << sh) & mask);
         e.rd = 1;
         q.push_back(e);
         e.rd = 0; e.wr = 1; e.dn = 1; e.wdata = merged;
         q.push_back(e);
      end
   endtask

   // One clock cycle: check outputs at negedge against the model, then act
   // as a synchronous RAM returning read data after the rising edge.
   task automatic step();
      exp_t e;
      bit   idle_exp;
      @(negedge clk);
      s_ready = req_ready; s_rd = mem_rd_en; s_wr = mem_wr_en;
      s_done = done; s_err = err; s_addr = mem_addr; s_wdata = mem_wdata;
      if (req_valid && s_ready && !rst) dut_acc++;
      if (rst) begin
         q.delete();
         chk("rst_ready", {31'b0, s_ready}, 32'd1);
         chk("rst_rd", {31'b0, s_rd}, 32'd0);
         chk("rst_wr", {31'b0, s_wr}, 32'd0);
         chk("rst_done", {31'b0, s_done}, 32'd0);
         chk("rst_err", {31'b0, s_err}, 32'd0);
         chk("rst_addr", s_addr, 32'd0);
         chk("rst_wdata", s_wdata, 32'd0);
      end else begin
         idle_exp = (q.size() == 0);
         if (idle_exp) e = '{default: '0};
         else e = q.pop_front();
         chk("ready", {31'b0, s_ready}, {31'b0, idle_exp});
         chk("rd_en", {31'b0, s_rd}, {31'b0, e.rd});
         chk("wr_en", {31'b0, s_wr}, {31'b0, e.wr});
         chk("done", {31'b0, s_done}, {31'b0, e.dn});
         chk("err", {31'b0, s_err}, {31'b0, e.er});
         if (e.rd || e.wr) chk("mem_addr", s_addr, e.addr);
         if (e.wr) begin
            chk("mem_wdata", s_wdata, e.wdata);
            mem[e.addr[9:2]] = e.wdata;
         end
         if (e.dn || e.er) begin
            n_txn++;
            $display("txn %0d: f3=%b addr=%h -> %s wdata=%h", n_txn, e.f3, e.addr,
                     e.er ? "err" : "store", s_wdata);
         end
         if (idle_exp && req_valid) model_accept();
      end
      @(posedge clk);
      #1;
      mem_rdata = s_rd ? mem[s_addr[9:2]] : $urandom();
   endtask

   task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      req_valid = v; function3 = f; addr = a; wdata = d;
   endtask

   int acc0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom();
      rst = 1'b1;
      drive(0, 3'b000, 32'h0, 32'h0);
      mem_rdata = 32'h0;

      // Reset state
      step(); step();
      chk("lit_reset_ready", {31'b0, s_ready}, 32'd1);
      chk("lit_reset_wr", {31'b0, s_wr}, 32'd0);
      rst = 1'b0;
      step();

      // sw 0x100 <- DEADBEEF
      drive(1, 3'b010, 32'h100, 32'hDEADBEEF);
      step();
      chk("lit_sw_accept_ready", {31'b0, s_ready}, 32'd1);
      drive(0, 3'b000, 32'h0, 32'h0);
      step();
      chk("lit_sw_wr", {31'b0, s_wr}, 32'd1);
      chk("lit_sw_rd", {31'b0, s_rd}, 32'd0);
      chk("lit_sw_done", {31'b0, s_done}, 32'd1);
      chk("lit_sw_addr", s_addr, 32'h100);
      chk("lit_sw_wdata", s_wdata, 32'hDEADBEEF);
      step();

      // sb 0x103 <- AA over 0x11223344
      mem[8'h40] = 32'h11223344;
      drive(1, 3'b000, 32'h103, 32'h000000AA);
      step();
      drive(0, 3'b000, 32'h0, 32'h0);
      step();
      chk("lit_sb_rd", {31'b0, s_rd}, 32'd1);
      chk("lit_sb_rd_addr", s_addr, 32'h100);
      step();
      chk("lit_sb_wr", {31'b0, s_wr}, 32'd1);
      chk("lit_sb_wdata", s_wdata, 32'hAA223344);
      step();

      // sh 0x202 <- BEEF over 0x11223344
      mem[8'h80] = 32'h11223344;
      drive(1, 3'b001, 32'h202, 32'h0000BEEF);
      step();
      drive(0, 3'b000, 32'h0, 32'h0);
      step();
      step();
      chk("lit_sh_wr", {31'b0, s_wr}, 32'd1);
      chk("lit_sh_addr", s_addr, 32'h200);
      chk("lit_sh_wdata", s_wdata, 32'hBEEF3344);
      step();

      // Invalid function3
      drive(1, 3'b011, 32'h100, 32'h12345678);
      step();
      drive(0, 3'b000, 32'h0, 32'h0);
      step();
      chk("lit_bad_f3_err", {31'b0, s_err}, 32'd1);
      chk("lit_bad_f3_wr", {31'b0, s_wr}, 32'd0);
      chk("lit_bad_f3_rd", {31'b0, s_rd}, 32'd0);
      step();
      chk("lit_bad_f3_ready", {31'b0, s_ready}, 32'd1);

      // Misaligned sw
      drive(1, 3'b010, 32'h101, 32'hCAFEF00D);
      step();
      drive(0, 3'b000, 32'h0, 32'h0);
      step();
`ifdef STORE_MISALIGN_TRAP_EN
      chk("lit_missw_err", {31'b0, s_err}, 32'd1);
      chk("lit_missw_wr", {31'b0, s_wr}, 32'd0);
`else
      chk("lit_missw_wr", {31'b0, s_wr}, 32'd1);
      chk("lit_missw_addr", s_addr, 32'h100);
      chk("lit_missw_wdata", s_wdata, 32'hCAFEF00D);
`endif
      step();

      // Reset while an sb is in READ
      drive(1, 3'b000, 32'h105, 32'h00000077);
      step();
      drive(0, 3'b000, 32'h0, 32'h0);
      rst = 1'b1;
      step();
      chk("lit_abort_rd", {31'b0, s_rd}, 32'd0);
      chk("lit_abort_wr", {31'b0, s_wr}, 32'd0);
      rst = 1'b0;
      step();
      chk("lit_abort_ready", {31'b0, s_ready}, 32'd1);
      chk("lit_abort_nowr", {31'b0, s_wr}, 32'd0);
      step();
      chk("lit_abort_nowr2", {31'b0, s_wr}, 32'd0);

      // req_valid held high through an sb
      acc0 = dut_acc;
      drive(1, 3'b000, 32'h108, 32'h00000055);
      step();
      step();
      chk("lit_held_ready_read", {31'b0, s_ready}, 32'd0);
      step();
      chk("lit_held_done", {31'b0, s_done}, 32'd1);
      chk("lit_held_one_accept", dut_acc - acc0, 32'd1);
      step();
      chk("lit_held_ready_again", {31'b0, s_ready}, 32'd1);
      chk("lit_held_two_accepts", dut_acc - acc0, 32'd2);
      drive(0, 3'b000, 32'h0, 32'h0);
      step(); step(); step();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [2:0] f;
         f = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
         drive(($urandom_range(0, 3) != 0), f, 32'h100 + $urandom_range(0, 255), $urandom());
         rst = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 1'b0;
      drive(0, 3'b000, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
